accum_sample_buffer: RTL

ACCUM_SAMPLE_BUFFER -- requirements
Module: accum_sample_buffer

---
 rtl/accum_pkg.sv | 10 +
 rtl/sample_fifo.sv | 57 +++++
 rtl/accum_sample_buffer.sv | 77 +++++++
 3 files changed

// File: rtl/accum_pkg.sv
// Shared constants and the buffered sample record for the accumulator sample buffer.
package accum_pkg;
  localparam int ACC_WIDTH = 4;
  localparam int ACC_DEPTH = 4;

  typedef struct packed {
    logic                 wrap;
    logic [ACC_WIDTH-1:0] sum;
  } sample_t;
endpackage

// File: rtl/sample_fifo.sv
// Sample storage: DEPTH-entry circular buffer with occupancy count.
module sample_fifo
  import accum_pkg::*;
#(
  parameter int DW    = $bits(sample_t),
  parameter int DEPTH = ACC_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/accum_sample_buffer.sv
// Captures Data+RegSum samples into a FIFO and tracks drop / wrap statistics.
module accum_sample_buffer
  import accum_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH,
  parameter int DEPTH = ACC_DEPTH
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [WIDTH-1:0]       Data,
  input  logic [WIDTH-1:0]       RegSum,
  input  logic                   SampleEn,
  input  logic                   ClearStat,
  input  logic                   OutReady,
  output logic                   OutValid,
  output logic [WIDTH-1:0]       OutSum,
  output logic                   OutWrap,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Overflow,
  output logic [7:0]             WrapCount
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Same layout as sample_t, but sized by this instance's WIDTH.
  typedef struct packed {
    logic             wrap;
    logic [WIDTH-1:0] sum;
  } samp_t;

  samp_t samp, head;
  logic  push, pop, drop;
  logic  overflow_q, overflow_d;
  logic [7:0] wrap_cnt_q, wrap_cnt_d;

  assign samp = {1'b0, Data} + {1'b0, RegSum};
  assign pop  = OutValid & OutReady;
  assign push = SampleEn & ((Count != FULL) | pop);
  assign drop = SampleEn & ~push;

  sample_fifo #(.DW($bits(samp_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (Clock),
    .rst_n (Reset),
    .push  (push),
    .wdata (samp),
    .pop   (pop),
    .rdata (head),
    .count (Count)
  );

  // Clear wins over a same-cycle drop or wrap push.
  always_comb begin
    overflow_d = overflow_q | drop;
    wrap_cnt_d = wrap_cnt_q;
    if (push && samp.wrap && wrap_cnt_q != 8'hFF) wrap_cnt_d = wrap_cnt_q + 8'd1;
    if (ClearStat) begin
      overflow_d = 1'b0;
      wrap_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      overflow_q <= 1'b0;
      wrap_cnt_q <= 8'd0;
    end else begin
      overflow_q <= overflow_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign OutValid  = (Count != '0);
  assign OutSum    = head.sum;
  assign OutWrap   = head.wrap;
  assign Overflow  = overflow_q;
  assign WrapCount = wrap_cnt_q;
endmodule
